// File: rtl/boot_pkg.sv
// Shared definitions for the UART boot loader: FSM states, frame marker
// and default sizing/timing constants.
package boot_pkg;

    typedef enum logic [2:0] {
        WAIT_SYNC,
        LEN_HI,
        LEN_LO,
        DATA,
        CSUM,
        RUN,
        ERR
    } boot_state_t;

    localparam logic [7:0]  SYNC_BYTE            = 8'hA5;
    localparam int unsigned DEF_MEM_WORDS        = 2048;
    localparam int unsigned DEF_BOOT_WAIT        = 50_000_000;
    localparam int unsigned DEF_BYTE_TIMEOUT     = 5_000_000;

    // True while a frame is being received and the inter-byte timeout applies.
    function automatic logic in_frame(input boot_state_t s);
        return (s == LEN_HI) || (s == LEN_LO) || (s == DATA) || (s == CSUM);
    endfunction

endpackage

// File: rtl/boot_timer.sv
// Loadable down-counter. Reset and load both restore the load value; the
// expire flag is high while the count sits at zero, where it stays.
module boot_timer
    import boot_pkg::*;
#(
    parameter int unsigned WIDTH = 32
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_val,
    input  logic             load,
    input  logic             dec,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    // Reload on reset or load, otherwise count down to zero and stop there.
    always_ff @(posedge clk) begin
        if (!rst || load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/uart_boot_loader.sv
// UART boot loader: parses SYNC / length / data / checksum frames from the
// serial receiver, writes big-endian words into RAM, and holds the core in
// reset until an image is loaded or the boot window runs out.
module uart_boot_loader
    import boot_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int unsigned MEM_WORDS    = DEF_MEM_WORDS,
    parameter int unsigned BOOT_WAIT    = DEF_BOOT_WAIT,
    parameter int unsigned BYTE_TIMEOUT = DEF_BYTE_TIMEOUT
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic [3:0]  mem_wren,
    output logic        core_hold,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] words_loaded
);

    boot_state_t state;
    logic [15:0] len;
    logic [15:0] len_next;
    logic [15:0] words_next;
    logic [7:0]  csum;
    logic [7:0]  csum_next;
    logic [1:0]  byte_idx;
    logic [23:0] word_buf;
    logic        sync_seen;
    logic        frame_active;
    logic        wait_expired;
    logic        byte_expired;

    assign frame_active = in_frame(state);
    assign sync_seen    = rx_valid && (rx_data == SYNC_BYTE);
    assign len_next     = {len[15:8], rx_data};
    assign words_next   = words_loaded + 16'd1;
    assign csum_next    = csum ^ rx_data;

    // Boot window: only runs while no frame has ever started.
    boot_timer #(.WIDTH(32)) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .load_val (32'(BOOT_WAIT - 1)),
        .load     (1'b0),
        .dec      (state == WAIT_SYNC),
        .expired  (wait_expired)
    );

    // Inter-byte timeout: rearmed by every byte and whenever no frame is open.
    boot_timer #(.WIDTH(32)) u_byte_timer (
        .clk      (clk),
        .rst      (rst),
        .load_val (32'(BYTE_TIMEOUT - 1)),
        .load     (rx_valid || !frame_active),
        .dec      (frame_active),
        .expired  (byte_expired)
    );

    // Frame parser, word assembler, checksum and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= WAIT_SYNC;
            len          <= 16'h0000;
            csum         <= 8'h00;
            byte_idx     <= 2'd0;
            word_buf     <= 24'h000000;
            mem_addr     <= 32'h0000_0000;
            mem_din      <= 32'h0000_0000;
            mem_wren     <= 4'h0;
            core_hold    <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= 16'h0000;
        end else begin
            mem_wren <= 4'h0;
            if (frame_active && !rx_valid && byte_expired) begin
                state <= ERR;
                err   <= 1'b1;
                busy  <= 1'b0;
            end else begin
                case (state)
                    WAIT_SYNC, ERR: begin
                        if (sync_seen) begin
                            state        <= LEN_HI;
                            busy         <= 1'b1;
                            err          <= 1'b0;
                            csum         <= 8'h00;
                            words_loaded <= 16'h0000;
                        end else if ((state == WAIT_SYNC) && wait_expired) begin
                            state     <= RUN;
                            core_hold <= 1'b0;
                        end
                    end
                    LEN_HI: begin
                        if (rx_valid) begin
                            len[15:8] <= rx_data;
                            csum      <= csum_next;
                            state     <= LEN_LO;
                        end
                    end
                    LEN_LO: begin
                        if (rx_valid) begin
                            len  <= len_next;
                            csum <= csum_next;
                            if ({16'h0000, len_next} > MEM_WORDS) begin
                                state <= ERR;
                                err   <= 1'b1;
                                busy  <= 1'b0;
                            end else if (len_next == 16'h0000) begin
                                state <= CSUM;
                            end else begin
                                state    <= DATA;
                                byte_idx <= 2'd0;
                            end
                        end
                    end
                    DATA: begin
                        if (rx_valid) begin
                            csum <= csum_next;
                            if (byte_idx == 2'd3) begin
                                mem_wren     <= 4'hF;
                                mem_addr     <= BASE_ADDR + {14'h0000, words_loaded, 2'b00};
                                mem_din      <= {word_buf, rx_data};
                                words_loaded <= words_next;
                                byte_idx     <= 2'd0;
                                if (words_next == len) begin
                                    state <= CSUM;
                                end
                            end else begin
                                word_buf <= {word_buf[15:0], rx_data};
                                byte_idx <= byte_idx + 2'd1;
                            end
                        end
                    end
                    CSUM: begin
                        if (rx_valid) begin
                            if (rx_data == csum) begin
                                state     <= RUN;
                                done      <= 1'b1;
                                busy      <= 1'b0;
                                core_hold <= 1'b0;
                            end else begin
                                state <= ERR;
                                err   <= 1'b1;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    RUN: begin
                        state <= RUN;
                    end
                    default: begin
                        state <= ERR;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for the UART boot loader: stimulus tasks queue the writes
// each frame should produce, and a negedge monitor checks every write pulse.
module tb_uart_boot_loader;

    localparam int unsigned BW   = 100;
    localparam int unsigned BT   = 50;
    localparam logic [7:0]  SYNC = 8'hA5;

    logic        clk      = 1'b0;
    logic        rst      = 1'b0;
    logic [7:0]  rx_data  = 8'h00;
    logic        rx_valid = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [3:0]  mem_wren;
    logic        core_hold;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] words_loaded;

    uart_boot_loader #(
        .BASE_ADDR    (32'h0000_0000),
        .MEM_WORDS    (2048),
        .BOOT_WAIT    (BW),
        .BYTE_TIMEOUT (BT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .mem_wren     (mem_wren),
        .core_hold    (core_hold),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [15:0] words;
        int          at;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [31:0] frame_words[$];

    // Cycle counter used to time-stamp expected write pulses.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, act, want);
        end
    endtask

    // Monitor: every write pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (mem_wren !== 4'h0) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL unexpected_write: got wren=%h addr=%h din=%h want no write",
                         mem_wren, mem_addr, mem_din);
            end else begin
                mon_e = exp_q.pop_front();
                if (mem_wren !== 4'hF || mem_addr !== mon_e.addr || mem_din !== mon_e.data ||
                    words_loaded !== mon_e.words || cyc != mon_e.at) begin
                    bad++;
                    $display("[TB] FAIL write: got wren=%h addr=%h din=%h words=%0d cyc=%0d want wren=f addr=%h din=%h words=%0d cyc=%0d",
                             mem_wren, mem_addr, mem_din, words_loaded, cyc,
                             mon_e.addr, mon_e.data, mon_e.words, mon_e.at);
                end
            end
        end
    end

    // Hard time limit in case the run gets stuck somewhere.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no end of test want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        rst      = 1'b0;
        tick();
        tick();
        check_output("reset_flags", 32'({core_hold, busy, done, err, mem_wren, words_loaded}),
                     32'({1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000}));
        check_output("reset_addr", mem_addr, 32'h0);
        check_output("reset_din", mem_din, 32'h0);
        rst = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) tick();
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic fill_random(input int n);
        frame_words.delete();
        for (int i = 0; i < n; i++) frame_words.push_back($urandom());
    endtask

    // Sends a full frame built from frame_words; the reference model is the
    // XOR of every byte after sync plus one expected write per whole word.
    task automatic apply_stimulus(input logic [15:0] n, input bit corrupt, input int max_gap);
        logic [7:0]  cs;
        logic [31:0] w;
        wr_t         e;
        cs = n[15:8] ^ n[7:0];
        for (int i = 0; i < int'(n); i++) begin
            w  = frame_words[i];
            cs = cs ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
        end
        send_byte(SYNC, int'($urandom_range(max_gap, 0)));
        check_output("sync_busy_err", 32'({busy, err}), 32'(2'b10));
        send_byte(n[15:8], int'($urandom_range(max_gap, 0)));
        send_byte(n[7:0], int'($urandom_range(max_gap, 0)));
        for (int i = 0; i < int'(n); i++) begin
            w = frame_words[i];
            for (int k = 0; k < 4; k++) begin
                send_byte(w[31-8*k -: 8], int'($urandom_range(max_gap, 0)));
                if (k == 3) begin
                    e.addr  = 32'(4 * i);
                    e.data  = w;
                    e.words = 16'(i + 1);
                    e.at    = cyc;
                    exp_q.push_back(e);
                end
            end
        end
        send_byte(corrupt ? (cs ^ 8'h10) : cs, int'($urandom_range(max_gap, 0)));
        if (corrupt)
            check_output("frame_end_bad", 32'({core_hold, busy, done, err}), 32'(4'b1001));
        else
            check_output("frame_end_good", 32'({core_hold, busy, done, err}), 32'(4'b0010));
        check_output("frame_words", 32'(words_loaded), 32'(n));
        check_output("frame_drained", 32'(exp_q.size()), 32'h0);
    endtask

    int k;

    initial begin
        $display("[TB] start");

        // Boot window expiry with no bytes at all.
        do_reset();
        k = 0;
        while (core_hold && k < 300) begin
            tick();
            k++;
        end
        check_output("boot_wait_cycles", 32'(k), 32'(BW));
        check_output("boot_wait_flags", 32'({done, busy, err}), 32'h0);
        send_byte(SYNC, 0);
        check_output("run_ignores_rx", 32'({busy, core_hold}), 32'h0);

        // Known two-word frame.
        do_reset();
        frame_words = '{32'hDEADBEEF, 32'h01234567};
        apply_stimulus(16'd2, 1'b0, 1);
        check_output("addr_hold", mem_addr, 32'h0000_0004);
        check_output("din_hold", mem_din, 32'h0123_4567);

        // Bad checksum, then the correct frame without reset.
        do_reset();
        apply_stimulus(16'd2, 1'b1, 2);
        apply_stimulus(16'd2, 1'b0, 2);

        // Oversized length.
        do_reset();
        send_byte(SYNC, 0);
        send_byte(8'h08, 0);
        send_byte(8'h01, 0);
        check_output("len_too_big", 32'({core_hold, busy, done, err}), 32'(4'b1001));
        repeat (5) tick();
        check_output("len_too_big_hold", 32'({core_hold, err, words_loaded}), 32'({1'b1, 1'b1, 16'h0}));

        // Inter-byte timeout after two data bytes.
        do_reset();
        send_byte(SYNC, 1);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        k = 0;
        while (!err && k < 200) begin
            tick();
            k++;
        end
        check_output("timeout_cycles", 32'(k), 32'(BT));
        check_output("timeout_flags", 32'({core_hold, busy, done, words_loaded}), 32'({1'b1, 1'b0, 1'b0, 16'h0}));

        // Back-to-back bytes.
        do_reset();
        fill_random(4);
        apply_stimulus(16'd4, 1'b0, 0);

        // Reset in the middle of the data phase.
        do_reset();
        fill_random(1);
        send_byte(SYNC, 0);
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        for (int i = 0; i < 4; i++) send_byte(frame_words[0][31-8*i -: 8], 0);
        mon_e.addr  = 32'h0;
        mon_e.data  = frame_words[0];
        mon_e.words = 16'd1;
        mon_e.at    = cyc;
        exp_q.push_back(mon_e);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        rst = 1'b0;
        tick();
        check_output("midreset_state", 32'({core_hold, busy, done, err, mem_wren, words_loaded}),
                     32'({1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000}));
        rst = 1'b1;
        k = 0;
        while (core_hold && k < 300) begin
            tick();
            k++;
        end
        check_output("midreset_rewait", 32'(k), 32'(BW));
        check_output("midreset_drained", 32'(exp_q.size()), 32'h0);

        // Random frames with random gaps and occasional checksum corruption.
        for (int it = 0; it < 8; it++) begin
            int  n;
            bit  corrupt;
            do_reset();
            n       = int'($urandom_range(5, 0));
            corrupt = ($urandom_range(3, 0) == 0);
            fill_random(n);
            apply_stimulus(16'(n), corrupt, 3);
        end

        tick();
        check_output("final_drained", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
Sits upstream of the core/memory pair at top level. It consumes the byte stream from the serial receiver after power-up and writes a program image into the 8K instruction/data RAM through the memory write port. It holds the core in reset until the image is loaded, or until the boot window expires with no image sent. After that it releases the core and goes passive.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of the first loaded word
MEM_WORDS, 2048, maximum word count accepted (8 KB)
BOOT_WAIT, 50_000_000, cycles to wait for the sync byte after reset before running the existing RAM contents
BYTE_TIMEOUT, 5_000_000, maximum cycles between consecutive bytes inside a frame
SYNC_BYTE, 8'hA5, frame start marker

Ports:
clk  in  1  system clock (same CLK as core and RAM)
rst  in  1  synchronous, active-low reset
rx_data  in  8  received byte from UART receiver
rx_valid  in  1  one-cycle strobe; rx_data valid
mem_addr  out  32  RAM byte address (word aligned)
mem_din  out  32  RAM write data
mem_wren  out  4  RAM byte-lane write enables
core_hold  out  1  active-high; drives core reset (ORed with sys reset at top)
busy  out  1  frame in progress
done  out  1  image loaded and checksum OK (sticky until reset)
err  out  1  last frame failed (sticky until next good sync)
words_loaded  out  16  words written in current/last frame

Behaviour:
- Reset (rst=0 at clk edge): state=WAIT_SYNC, mem_addr=0, mem_din=0, mem_wren=0, core_hold=1, busy=0, done=0, err=0, words_loaded=0, wait timer=0.
- Reset asserted mid-frame: frame abandoned, no further writes. Previously written words stay in RAM.
- States: WAIT_SYNC, LEN_HI, LEN_LO, DATA, CSUM, RUN, ERR.
- WAIT_SYNC: if rx_valid and rx_data==SYNC_BYTE, go to LEN_HI, set busy=1, clear err, checksum=0, words_loaded=0. Other bytes are ignored. The wait timer counts every cycle while no frame has ever started. When it reaches BOOT_WAIT-1, go to RUN without writing.
- The wait timer runs only until the first sync is received. After an ERR, the block waits for sync indefinitely.
- LEN_HI / LEN_LO: big-endian 16-bit word count N. Each byte is XORed into the checksum.
- After LEN_LO:
  - N > MEM_WORDS goes to ERR.
  - N == 0 goes to CSUM.
  - Otherwise go to DATA with byte_idx=0.
- DATA: bytes are assembled big-endian; the first byte goes to bits [31:24].
  - On the 4th byte, the next cycle presents one pulse of mem_wren=4'hF, with mem_addr=BASE_ADDR+4*words_loaded (pre-increment) and mem_din=the assembled word.
  - words_loaded increments in the same cycle as the pulse.
  - After the Nth word, go to CSUM.
  - An rx_valid arriving during the write-pulse cycle is accepted normally.
- CSUM: the received byte is compared with the XOR of all bytes after sync (length bytes and data bytes).
  - Equal: go to RUN, set done=1.
  - Not equal: go to ERR.
- BYTE_TIMEOUT: in LEN_HI, LEN_LO, DATA and CSUM, a counter clears on each rx_valid. If it reaches BYTE_TIMEOUT-1, go to ERR.
- ERR: err=1, busy=0, core_hold stays 1. On the next rx_valid with SYNC_BYTE, restart the frame as if from WAIT_SYNC, minus the wait timer.
- RUN: core_hold=0 from the first cycle in RUN, which is one cycle after the CSUM byte or wait expiry. busy=0. All rx bytes are ignored; the core's UART owns the line. RUN exits only on reset.
- mem_wren is 0 except during write pulses. mem_addr and mem_din hold their last values between writes.
- Address arithmetic is 32-bit; words_loaded*4 cannot wrap because N ≤ MEM_WORDS.

Decomposition:
- Shared package boot_pkg holds:
  - the state enum;
  - SYNC_BYTE;
  - the default MEM_WORDS, BOOT_WAIT and BYTE_TIMEOUT constants.
- One sub-module, boot_timer: a loadable down-counter with clear and an expire flag. It is instantiated twice, once as the boot-wait timer and once as the inter-byte timer.
- The FSM, word assembler and checksum live in uart_boot_loader.

Test Plan:
- Reset, no bytes, BOOT_WAIT=100 → core_hold falls exactly 100 cycles after reset release; mem_wren never nonzero; done=0.
- Frame A5 00 02 DE AD BE EF 01 23 45 67 CS, with CS = 00^02^DE^AD^BE^EF^01^23^45^67 → writes 0xDEADBEEF at 0x0 and 0x01234567 at 0x4. Each write pulse comes one cycle after its 4th byte. done=1, core_hold=0, words_loaded=2.
- Same frame with the checksum bit-flipped → err=1, core_hold=1. Resending the correct frame then gives done=1 and err=0.
- Length 0x0801 (>2048) → ERR immediately after LEN_LO, with no writes.
- Stop sending after 2 data bytes, BYTE_TIMEOUT=50 → ERR 50 cycles after the last byte; no partial write.
- Bytes sent back-to-back on consecutive cycles → every word written. Reset asserted mid-DATA → state WAIT_SYNC, mem_wren=0, core_hold=1.
